// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a FIFO read port (FWFT or 1-cycle-latency)
// into a valid/ready stream with m_tlast every pkt_len words.
// A 2-entry in-order output buffer sustains one beat per clock.
// Optional feature macro: FIFO_READER_STATS_EN adds stat_pkts/stat_stall.
module fifo_stream_reader #(
  parameter int DW    = 8,
  parameter int FWFT  = 1,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_re,
  input  logic             enable,
  input  logic [LEN_W-1:0] pkt_len,
  output logic [DW-1:0]    m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             busy
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [15:0]      stat_pkts,
  output logic [15:0]      stat_stall
`endif
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;

  logic [1:0][DW-1:0] buf_data;
  logic [1:0]         buf_last;
  logic [1:0]         occ, occ_next;
  logic               infl, infl_last;
  logic [LEN_W-1:0]   wc, len_q, len_eff;
  logic               rd_last, beat;
  logic               wr_en, wr_last, wr_slot;
  logic [DW-1:0]      wr_data;

  // Stream side and framing decode
  always_comb begin
    m_tvalid = (occ != 2'd0);
    m_tdata  = buf_data[0];
    m_tlast  = m_tvalid && buf_last[0];
    beat     = m_tvalid && m_tready;
    // First read of a packet uses the live pkt_len; later reads use the latched copy.
    // A length of 0 wraps to all-ones here, giving 2**LEN_W words.
    len_eff  = (wc == '0) ? pkt_len : len_q;
    rd_last  = (wc == (len_eff - LEN_ONE));
  end

  // Buffer write source: same-cycle data for FWFT, returned data otherwise
  always_comb begin
    if (FWFT != 0) begin
      wr_en   = fifo_re;
      wr_last = rd_last;
    end else begin
      wr_en   = infl;
      wr_last = infl_last;
    end
    wr_data = fifo_dout;
    // Slot after the (possible) shift: occ - beat
    wr_slot = (occ == 2'd2) || ((occ == 2'd1) && !beat);
    case ({wr_en, beat})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  // Output buffer: head at index 0, shifts forward on each beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data <= '0;
      buf_last <= '0;
      occ      <= '0;
    end else begin
      if (beat) begin
        buf_data[0] <= buf_data[1];
        buf_last[0] <= buf_last[1];
      end
      if (wr_en) begin
        buf_data[wr_slot] <= wr_data;
        buf_last[wr_slot] <= wr_last;
      end
      occ <= occ_next;
    end
  end

  // Pending non-FWFT read and word counter / length latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl      <= 1'b0;
      infl_last <= 1'b0;
      wc        <= '0;
      len_q     <= '0;
    end else begin
      infl <= (FWFT == 0) && fifo_re;
      if (fifo_re) begin
        infl_last <= rd_last;
        if (wc == '0) len_q <= pkt_len;
        wc <= rd_last ? '0 : wc + LEN_ONE;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state: stop only once the last read of a packet is issued
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (fifo_re && rd_last && !enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: read issue keeps occupancy plus in-flight at most 2
  always_comb begin
    fifo_re = (state == RUN) && !fifo_empty &&
              (({1'b0, occ} + {2'b00, infl}) < (3'd2 + {2'b00, beat}));
    busy    = (state == RUN) || (occ != 2'd0) || infl;
  end

`ifdef FIFO_READER_STATS_EN
  // Saturating packet and stall counters, cleared while idle and disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkts  <= '0;
      stat_stall <= '0;
    end else if (!enable && (state == IDLE)) begin
      stat_pkts  <= '0;
      stat_stall <= '0;
    end else begin
      if (beat && m_tlast && (stat_pkts != '1)) stat_pkts <= stat_pkts + 16'd1;
      if (m_tvalid && !m_tready && (stat_stall != '1)) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: instance A (FWFT=1, LEN_W=3), instance B
// (FWFT=0, LEN_W=8), each fed by a small FIFO model, checked by a scoreboard.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A signals
  logic [7:0] a_fifo_dout;
  logic       a_fifo_empty, a_fifo_re, a_enable, a_tvalid, a_tready, a_tlast, a_busy;
  logic [2:0] a_pkt_len;
  logic [7:0] a_tdata;
  // Instance B signals
  logic [7:0] b_fifo_dout;
  logic       b_fifo_empty, b_fifo_re, b_enable, b_tvalid, b_tready, b_tlast, b_busy;
  logic [7:0] b_pkt_len;
  logic [7:0] b_tdata;
`ifdef FIFO_READER_STATS_EN
  logic [15:0] a_stat_pkts, a_stat_stall, b_stat_pkts, b_stat_stall;
`endif

  fifo_stream_reader #(.DW(8), .FWFT(1), .LEN_W(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .fifo_dout(a_fifo_dout), .fifo_empty(a_fifo_empty),
    .fifo_re(a_fifo_re), .enable(a_enable), .pkt_len(a_pkt_len), .m_tdata(a_tdata),
    .m_tvalid(a_tvalid), .m_tready(a_tready), .m_tlast(a_tlast), .busy(a_busy)
`ifdef FIFO_READER_STATS_EN
    , .stat_pkts(a_stat_pkts), .stat_stall(a_stat_stall)
`endif
  );

  fifo_stream_reader #(.DW(8), .FWFT(0), .LEN_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .fifo_dout(b_fifo_dout), .fifo_empty(b_fifo_empty),
    .fifo_re(b_fifo_re), .enable(b_enable), .pkt_len(b_pkt_len), .m_tdata(b_tdata),
    .m_tvalid(b_tvalid), .m_tready(b_tready), .m_tlast(b_tlast), .busy(b_busy)
`ifdef FIFO_READER_STATS_EN
    , .stat_pkts(b_stat_pkts), .stat_stall(b_stat_stall)
`endif
  );

  // FIFO models: A is first-word-fall-through, B returns data one clock after the pop
  logic [7:0] a_mem [256];
  logic [7:0] b_mem [256];
  int a_wp = 0, a_rp = 0, b_wp = 0, b_rp = 0;
  assign a_fifo_empty = (a_rp == a_wp);
  assign a_fifo_dout  = a_mem[a_rp % 256];
  assign b_fifo_empty = (b_rp == b_wp);

  always @(posedge clk) begin
    if (a_fifo_re) a_rp <= a_rp + 1;
  end

  always @(posedge clk) begin
    if (b_fifo_re) begin
      b_fifo_dout <= b_mem[b_rp % 256];
      b_rp        <= b_rp + 1;
    end
  end

  // Scoreboards and observation logs
  logic [8:0] a_exp [$];
  logic [8:0] b_exp [$];
  int a_re_log [$];
  int a_beat_log [$];
  int b_re_log [$];
  int b_beat_log [$];
  int cyc = 0;
  int n_chk = 0, n_pass = 0;
  int a_occ = 0, a_pkts = 0, a_stall = 0;
  logic a_prev_stall = 1'b0;
  logic [7:0] a_hd;
  logic a_hl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_a(input logic [7:0] d, input logic l);
    a_mem[a_wp % 256] = d;
    a_wp = a_wp + 1;
    a_exp.push_back({l, d});
  endtask

  task automatic push_b(input logic [7:0] d, input logic l);
    b_mem[b_wp % 256] = d;
    b_wp = b_wp + 1;
    b_exp.push_back({l, d});
  endtask

  // Observe both streams mid-cycle; a beat seen here completes at the next edge
  task automatic monitor();
    logic [8:0] e;
    if (!rst_n) begin
      a_prev_stall = 1'b0;
      a_occ = 0;
      a_pkts = 0;
      a_stall = 0;
    end else begin
      if (a_prev_stall) begin
        chk("a_hold_valid", a_tvalid, 1);
        chk("a_hold_data", a_tdata, a_hd);
        chk("a_hold_last", a_tlast, a_hl);
      end
      chk("a_occ_le2", (a_occ <= 2), 1);
      chk("a_valid_vs_occ", a_tvalid, (a_occ != 0));
      if (a_fifo_re) a_re_log.push_back(cyc);
      if (a_tvalid && a_tready) begin
        if (a_exp.size() == 0) chk("a_extra_beat", a_tvalid, 0);
        else begin
          e = a_exp.pop_front();
          chk("a_data", a_tdata, e[7:0]);
          chk("a_last", a_tlast, e[8]);
        end
        a_beat_log.push_back(cyc);
        if (a_tlast) a_pkts++;
      end
      if (a_tvalid && !a_tready) a_stall++;
      a_prev_stall = a_tvalid && !a_tready;
      a_hd = a_tdata;
      a_hl = a_tlast;
      a_occ = a_occ + (a_fifo_re ? 1 : 0) - ((a_tvalid && a_tready) ? 1 : 0);

      if (b_fifo_re) b_re_log.push_back(cyc);
      if (b_tvalid && b_tready) begin
        if (b_exp.size() == 0) chk("b_extra_beat", b_tvalid, 0);
        else begin
          e = b_exp.pop_front();
          chk("b_data", b_tdata, e[7:0]);
          chk("b_last", b_tlast, e[8]);
        end
        b_beat_log.push_back(cyc);
      end
    end
  endtask

  // One clock: observe at the falling edge, return just after the rising edge
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_a(input int budget, input string tag);
    for (int i = 0; i < budget && a_exp.size() != 0; i++) tick();
    chk(tag, a_exp.size(), 0);
  endtask

  task automatic wait_b(input int budget, input string tag);
    for (int i = 0; i < budget && b_exp.size() != 0; i++) tick();
    chk(tag, b_exp.size(), 0);
  endtask

  initial begin
    int rb, bb, rem;
    rst_n = 1'b0;
    a_enable = 1'b0; b_enable = 1'b0;
    a_tready = 1'b1; b_tready = 1'b1;
    a_pkt_len = 3'd4; b_pkt_len = 8'd4;
    tick();
    tick();

    // Reset state
    chk("rst_a_re", a_fifo_re, 0);
    chk("rst_a_valid", a_tvalid, 0);
    chk("rst_a_last", a_tlast, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_data", a_tdata, 0);
    chk("rst_b_re", b_fifo_re, 0);
    chk("rst_b_valid", b_tvalid, 0);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_b_data", b_tdata, 0);
`ifdef FIFO_READER_STATS_EN
    chk("rst_a_stat_pkts", a_stat_pkts, 0);
    chk("rst_a_stat_stall", a_stat_stall, 0);
`endif
    rst_n = 1'b1;
    tick();

    // 1: FWFT, two 4-word packets back to back
    rb = a_re_log.size();
    bb = a_beat_log.size();
    for (int i = 0; i < 8; i++) push_a(8'h10 + 8'(i), (i % 4) == 3);
    a_enable = 1'b1;
    wait_a(40, "t1_drain");
    chk("t1_beats", a_beat_log.size() - bb, 8);
    if (a_beat_log.size() >= bb + 8 && a_re_log.size() > rb) begin
      chk("t1_back2back", a_beat_log[bb+7] - a_beat_log[bb], 7);
      chk("t1_latency", a_beat_log[bb] - a_re_log[rb], 1);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_no_re", a_fifo_re, 0);
    end

    // 2: non-FWFT, same stimulus
    rb = b_re_log.size();
    bb = b_beat_log.size();
    for (int i = 0; i < 8; i++) push_b(8'h10 + 8'(i), (i % 4) == 3);
    b_enable = 1'b1;
    wait_b(40, "t2_drain");
    chk("t2_beats", b_beat_log.size() - bb, 8);
    if (b_beat_log.size() >= bb + 8 && b_re_log.size() > rb) begin
      chk("t2_back2back", b_beat_log[bb+7] - b_beat_log[bb], 7);
      chk("t2_latency", b_beat_log[bb] - b_re_log[rb], 2);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_no_re", b_fifo_re, 0);
    end

    // 3: ready toggling with 16 words queued
    for (int i = 0; i < 16; i++) push_a(8'h20 + 8'(i), (i % 4) == 3);
    for (int i = 0; i < 100 && a_exp.size() != 0; i++) begin
      a_tready = (i % 2) == 0;
      tick();
    end
    chk("t3_drain", a_exp.size(), 0);
    a_tready = 1'b1;

    // 4: enable dropped after two of four reads
    rb = a_re_log.size();
    push_a(8'h30, 1'b0);
    push_a(8'h31, 1'b0);
    for (int i = 0; i < 20 && a_re_log.size() < rb + 2; i++) tick();
    chk("t4_two_reads", a_re_log.size() - rb, 2);
    a_enable = 1'b0;
    chk("t4_busy_mid", a_busy, 1);
    push_a(8'h32, 1'b0);
    push_a(8'h33, 1'b1);
    wait_a(20, "t4_drain");
    chk("t4_busy_end", a_busy, 0);
    rb = a_re_log.size();
    a_mem[a_wp % 256] = 8'h3F;
    a_wp = a_wp + 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_no_re", a_fifo_re, 0);
      chk("t4_no_valid", a_tvalid, 0);
    end
    chk("t4_no_re_log", a_re_log.size() - rb, 0);

    // 5: pkt_len=0 gives 8 words; change to 2 mid-packet takes effect next packet
    a_pkt_len = 3'd0;
    a_exp.push_back({1'b0, 8'h3F});
    for (int i = 0; i < 7; i++) push_a(8'h40 + 8'(i), i == 6);
    push_a(8'h47, 1'b0);
    push_a(8'h48, 1'b1);
    rb = a_re_log.size();
    a_enable = 1'b1;
    for (int i = 0; i < 20 && a_re_log.size() < rb + 3; i++) tick();
    a_pkt_len = 3'd2;
    wait_a(60, "t5_drain");
    chk("t5_reads", a_re_log.size() - rb, 10);

    // 6: reset during beat 2; next read starts a fresh packet
    a_pkt_len = 3'd4;
    bb = a_beat_log.size();
    for (int i = 0; i < 4; i++) push_a(8'h50 + 8'(i), i == 3);
    for (int i = 0; i < 20 && a_beat_log.size() < bb + 1; i++) tick();
    chk("t6_beat1", a_beat_log.size() - bb, 1);
    chk("t6_valid_pre", a_tvalid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", a_tvalid, 0);
    chk("t6_rst_re", a_fifo_re, 0);
    chk("t6_rst_last", a_tlast, 0);
    chk("t6_rst_busy", a_busy, 0);
    chk("t6_rst_data", a_tdata, 0);
    // Words already popped are lost; rebuild expectations from what is left
    a_exp.delete();
    rem = a_wp - a_rp;
    for (int k = 0; k < rem; k++) a_exp.push_back({(k == 3), a_mem[(a_rp + k) % 256]});
    for (int k = rem; k < 4; k++) push_a(8'h60 + 8'(k), k == 3);
    tick();
    tick();
    a_tready = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t6_stalled_valid", a_tvalid, 1);
    a_tready = 1'b1;
    wait_a(30, "t6_drain");
    chk("t6_pkts_seen", a_pkts, 1);
`ifdef FIFO_READER_STATS_EN
    chk("t6_stat_pkts", a_stat_pkts, a_pkts);
    chk("t6_stat_stall", a_stat_stall, a_stall);
`endif

    tick();
    chk("end_b_empty", b_exp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
